// File: rtl/pipelined_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined add/subtract unit.
package pipelined_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Bits handled by each carry-linked slice.
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Operands must split into equal slices.
    function automatic bit div_ok(input int width, input int stages);
        return (stages > 0) && (width % stages == 0);
    endfunction

    localparam bit DEF_DIV_OK = div_ok(DEF_WIDTH, DEF_STAGES);

    // Base of stage k's field in the flattened operand skew register.
    // Stage k keeps the WIDTH-(k+1)*SLICE operand bits not yet consumed.
    function automatic int skew_off(input int width, input int stages, input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o += width - (j + 1) * slice_w(width, stages);
        return o;
    endfunction

    // Base of stage k's field in the flattened result de-skew register.
    // Stage k holds the (k+1)*SLICE low result bits produced so far.
    function automatic int res_off(input int width, input int stages, input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o += (j + 1) * slice_w(width, stages);
        return o;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The overflow signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(parameter int WIDTH = 16) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef PIPE_ADDER_OVF_EN
    logic             overflow;
`endif

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out
`ifdef PIPE_ADDER_OVF_EN
      , input  overflow
`endif
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out
`ifdef PIPE_ADDER_OVF_EN
      , output overflow
`endif
    );
endinterface

// File: rtl/pipelined_adder_slice.sv
// adder_slice: SLICE-bit combinational ripple of full-adder cells.
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co
);
    logic [SLICE:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign co = c[SLICE];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-linked
// slices, one register stage per slice, with a single global stall enable.
// Optional: define PIPE_ADDER_OVF_EN to add the registered signed-overflow flag.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int SLICE     = slice_w(WIDTH, STAGES);
    localparam int SKW_RAW   = skew_off(WIDTH, STAGES, STAGES - 1);
    localparam int SKW_BITS  = (SKW_RAW > 0) ? SKW_RAW : 1;
    localparam int RES_BITS  = res_off(WIDTH, STAGES, STAGES);
    localparam int ROFF_LAST = res_off(WIDTH, STAGES, STAGES - 1);

    if (!div_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic                en;
    logic                accept;
    logic [STAGES-1:0]   vld_q;
    logic [STAGES:0]     vld_pipe;
    logic [STAGES-1:0]   cy_q;
    logic [SKW_BITS-1:0] skew_a;
    logic [SKW_BITS-1:0] skew_b;
    logic [RES_BITS-1:0] res_q;
`ifdef PIPE_ADDER_OVF_EN
    logic                ovf_q;
`endif

    // A full output that is not being taken freezes the whole pipe, bubbles too.
    assign en       = !vld_q[STAGES-1] | bus.out_ready;
    assign accept   = bus.in_valid & en;
    assign vld_pipe = {vld_q, accept};

    // Valid bits shift one stage per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)  vld_q <= '0;
        else if (en) vld_q <= vld_pipe[STAGES-1:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW    = WIDTH - k * SLICE;          // operand bits still pending
        localparam int SKOFF = skew_off(WIDTH, STAGES, k);
        localparam int ROFF  = res_off(WIDTH, STAGES, k);

        logic [SW-1:0]          a_src;
        logic [SW-1:0]          b_src;
        logic                   c_src;
        logic [SLICE-1:0]       s_sl;
        logic                   c_sl;
        logic [(k+1)*SLICE-1:0] r_nxt;

        if (k == 0) begin : g_head
            op_e op;
            assign op    = op_e'(bus.sub);
            // Subtraction is a + ~b + 1; carry_in is ignored for it.
            assign a_src = bus.a;
            assign b_src = (op == OP_SUB) ? ~bus.b : bus.b;
            assign c_src = (op == OP_SUB) ? 1'b1 : bus.carry_in;
            assign r_nxt = s_sl;
        end else begin : g_tail
            localparam int SKOFF_P = skew_off(WIDTH, STAGES, k - 1);
            localparam int ROFF_P  = res_off(WIDTH, STAGES, k - 1);
            assign a_src = skew_a[SKOFF_P +: SW];
            assign b_src = skew_b[SKOFF_P +: SW];
            assign c_src = cy_q[k-1];
            assign r_nxt = {s_sl, res_q[ROFF_P +: k*SLICE]};
        end

        adder_slice #(.SLICE(SLICE)) u_slice (
            .a  (a_src[SLICE-1:0]),
            .b  (b_src[SLICE-1:0]),
            .ci (c_src),
            .s  (s_sl),
            .co (c_sl)
        );

        // Stage register: slice carry plus the result bits accumulated so far.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cy_q[k]                      <= 1'b0;
                res_q[ROFF +: (k+1)*SLICE]   <= '0;
            end else if (en) begin
                cy_q[k]                      <= c_sl;
                res_q[ROFF +: (k+1)*SLICE]   <= r_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            // Operand bits above this slice travel on to the next stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    skew_a[SKOFF +: SW-SLICE] <= '0;
                    skew_b[SKOFF +: SW-SLICE] <= '0;
                end else if (en) begin
                    skew_a[SKOFF +: SW-SLICE] <= a_src[SW-1:SLICE];
                    skew_b[SKOFF +: SW-SLICE] <= b_src[SW-1:SLICE];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            // Carry into MSB xor carry out, expressed via operand/result signs.
            always_ff @(posedge clk) begin
                if (!rst_n)  ovf_q <= 1'b0;
                else if (en) ovf_q <= (a_src[SW-1] ~^ b_src[SW-1]) & (s_sl[SLICE-1] ^ a_src[SW-1]);
            end
        end
`endif
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = res_q[ROFF_LAST +: WIDTH];
    assign bus.carry_out = cy_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
    assign bus.overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4).
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Reference for plain additions: exact (W+1)-bit sum, signed overflow by signs.
    function automatic exp_t golden_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] t;
        t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return mk(t[W-1:0], t[W], (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]));
    endfunction

    // Monitor: retire one expected result per output handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_result: got sum %0h with nothing outstanding", bus.sum);
            end else begin
                e = sb.pop_front();
                n_pop++;
                chk("sum", bus.sum, e.sum);
                chk("carry_out", bus.carry_out, e.cout);
`ifdef PIPE_ADDER_OVF_EN
                chk("overflow", bus.overflow, e.ovf);
`endif
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat, push its expected result on acceptance; leaves in_valid high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input exp_t e);
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready 0 for 50 cycles expected acceptance");
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c0;
        int p0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_sum", bus.sum, 0);
        chk("rst_carry_out", bus.carry_out, 0);
`ifdef PIPE_ADDER_OVF_EN
        chk("rst_overflow", bus.overflow, 0);
`endif
        @(posedge clk);
        #1;

        // First beat: result shows up STAGES cycles after it is presented
        send(16'h0001, 16'h0002, 1'b0, 1'b0, mk(16'h0003, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        for (int i = 1; i <= S; i++) begin
            @(negedge clk);
            chk("latency_out_valid", bus.out_valid, (i == S) ? 1 : 0);
            @(posedge clk);
            #1;
        end

        // Directed vectors, back to back
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0)); // carry across all slices
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0)); // borrow
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1)); // signed overflow on sub
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0, mk(16'h8000, 1'b0, 1'b1)); // carry_in into overflow
        send(16'h0003, 16'h0003, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0)); // carry_in ignored on sub
        bus.in_valid = 1'b0;
        wait_cycles(S + 2);
        chk("directed_drained", sb.size(), 0);

        // 20 back-to-back beats at full rate
        c0 = cyc;
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, 1'b0, golden_add(ra, rb, rc));
        end
        bus.in_valid = 1'b0;
        chk("b2b_accept_cycles", cyc - c0, 20);
        wait_cycles(S);
        chk("b2b_results", n_pop - p0, 20);

        // Stream 6 beats with a 5-cycle output stall in the middle
        p0 = n_pop;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(W'(i * 16'h1000), W'(i), 1'b0, 1'b0, mk(W'(i * 16'h1001), 1'b0, 1'b0));
                bus.in_valid = 1'b0;
            end
            begin
                wait_cycles(5);
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", bus.in_ready, 0);
                    chk("stall_out_valid", bus.out_valid, 1);
                    if (sb.size() > 0) chk("stall_sum_held", bus.sum, sb[0].sum);
                    else               chk("stall_outstanding", sb.size(), 1);
                    @(posedge clk);
                end
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_cycles(S + 2);
        chk("stall_results", n_pop - p0, 6);
        chk("stall_drained", sb.size(), 0);

        // Reset with 3 beats in flight: none may come out
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
        send(16'h1234, 16'h1111, 1'b0, 1'b0, mk(16'h2345, 1'b0, 1'b0));
        send(16'hF0F0, 16'h0F0F, 1'b0, 1'b0, mk(16'hFFFF, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        p0 = n_pop;
        wait_cycles(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_carry_out", bus.carry_out, 0);
        wait_cycles(10);
        chk("midrst_no_emit", n_pop - p0, 0);

        // Pipe still works after the flush
        send(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        bus.in_valid = 1'b0;
        wait_cycles(S + 2);
        chk("final_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit. Generalises the single-bit full adder to WIDTH bits by splitting the operands into STAGES equal carry-linked slices, with one register stage per slice. Accepts one operation per cycle under a valid/ready handshake and returns sum, carry-out and, optionally, a signed-overflow flag after STAGES cycles. It sits between operand producers and any consumer that needs registered arithmetic at clock rates a WIDTH-bit ripple chain cannot meet.

## Interface
- WIDTH, 16: operand/result width in bits.
- STAGES, 4: pipeline depth. WIDTH % STAGES == 0 is required; elaboration fails otherwise. SLICE = WIDTH/STAGES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts the beat this cycle.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0 (ignored when sub=1).
- sub  in  1  0: a+b+carry_in; 1: a-b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result this cycle.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of bit WIDTH-1 (for sub: 1 means no borrow).
- overflow  out  1  signed overflow (only with PIPE_ADDER_OVF_EN).

## Operation
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Slice k (0..STAGES-1) adds bits [k*SLICE +: SLICE] of A and B' (B' = sub ? ~b : b) with the carry registered by slice k-1. Slice 0 uses sub ? 1 : carry_in.
- Operand bits above the current slice travel down a skew register. Result bits below it travel down a de-skew register. Both are captured on accept.
- Each stage holds a valid bit. A beat advances one stage per enabled cycle.
- Global enable en = !out_valid | out_ready. When en=0 every stage holds, including bubbles.
- in_ready = en. A beat is accepted when in_valid && in_ready.
- sum is the full WIDTH-bit result modulo 2^WIDTH. carry_out is bit WIDTH of the exact sum.
- Reset clears all valid bits. sum, carry_out and overflow are 0; out_valid=0; in_ready=1 in the first cycle after reset.
- If reset is asserted mid-operation, all in-flight beats are dropped and no partial result is emitted.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, provided no stall occurs.
- Throughput: 1 beat/cycle while out_ready=1.
- While out_valid=1 and out_ready=0: sum, carry_out and overflow hold stable, in_ready=0, and no stage advances.
- Same-cycle out_ready and in_valid when the pipe is full: the result retires and the new beat is accepted in the same edge. There is no bubble.
- Combinational paths: out_ready -> in_ready only. There is no combinational path from the a/b inputs to any output.
- STAGES=1 degenerates to a single registered WIDTH-bit adder with latency 1.

## Configuration
- PIPE_ADDER_OVF_EN defined: the overflow port exists. It is registered with the final slice and equals carry into the MSB XOR carry_out. It is cleared by reset and held during stall.
- PIPE_ADDER_OVF_EN undefined: the overflow port and its sign-carry register are omitted. All other behaviour is identical.

## Structure
- Shared package pipelined_adder_pkg holds:
  - the slice-width function (WIDTH/STAGES);
  - an operation typedef {OP_ADD, OP_SUB};
  - the localparam check for the divisibility rule.
- One sub-module, adder_slice: a SLICE-bit combinational ripple of single-bit full-adder cells (sum = a^b^c, carry = ab|ac|bc) with carry in/out. The top level instantiates STAGES of them, each followed by the stage registers.

## Test plan
- Reset, then a=16'h0001, b=16'h0002, carry_in=0, sub=0 -> out_valid after 4 cycles; sum=16'h0003, carry_out=0.
- a=16'hFFFF, b=16'h0001, carry_in=0 -> sum=16'h0000, carry_out=1. This carry crosses all 4 slices.
- sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, carry_out=0 (borrow). With the macro: a=16'h8000, b=16'h0001 -> sum=16'h7FFF, overflow=1.
- 20 back-to-back random beats with out_ready=1 -> 20 results in order, one per cycle, each matching a golden a+b+cin.
- Stream 6 beats, drop out_ready for 5 cycles mid-stream -> in_ready=0 while stalled, the held result is unchanged, and no beat is lost or duplicated.
- Assert rst_n=0 for 1 cycle with 3 beats in flight -> next cycle out_valid=0 and sum=0; none of the 3 beats is ever emitted.
